clk_speed_sched: RTL
====================

CLK_SPEED_SCHED -- requirements
Module: clk_speed_sched

Interface
REQ-001 SHALL have parameter DCM_RST_CYCLES, default 8, meaning the number of cycles Dcm_rst is held high per reset attempt (range 1..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4095, meaning the number of cycles to wait for Dcm_locked before re-resetting the DCM (range 1..65535).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16, meaning the cycles of continuous lock required before run (range 1..255).
REQ-004 SHALL have port Clk_125M  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port Speed  input  3  requested line rate, one-hot: 3'b100 = 1000M, 3'b010 = 100M, 3'b001 = 10M; any other code is ignored.
REQ-007 SHALL have port Dcm_locked  input  1  DCM lock status, asynchronous to Clk_125M.
REQ-008 SHALL have port Dcm_rst  output  1  DCM reset request, active high.
REQ-009 SHALL have port Clk_ready  output  1  high only in state RUN.
REQ-010 SHALL have port Tx_en  output  1  single-cycle transmit clock enable for the MAC.
REQ-011 SHALL have port Speed_cur  output  3  one-hot speed currently applied.
REQ-012 SHALL have port Speed_chg  output  1  one-cycle pulse when Speed_cur changes.

Function
REQ-013 SHALL pass Dcm_locked and Speed through a 2-flop synchronizer each; all decisions use the synchronized values.
REQ-014 SHALL implement FSM states DCM_RST, WAIT_LOCK, SETTLE and RUN.
REQ-015 DCM_RST SHALL assert Dcm_rst for exactly DCM_RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-016 WAIT_LOCK SHALL go to SETTLE on a synchronized lock, or to DCM_RST after LOCK_TIMEOUT cycles without lock; if both happen in the same cycle, lock wins.
REQ-017 SHALL leave SETTLE for RUN after SETTLE_CYCLES consecutive locked cycles; any lock drop during SETTLE SHALL return the FSM to WAIT_LOCK with the counter cleared.
REQ-018 In RUN, on a lock drop, SHALL behave as defined in REQ-027 and REQ-028.
REQ-019 In RUN, the divider SHALL count modulo 1, 10 or 100 for 1000M, 100M or 10M; Tx_en SHALL be high exactly when the divider is 0.
REQ-020 Tx_en SHALL be 0 in every state other than RUN; on entry to RUN the divider starts at 0, so Tx_en rises the first RUN cycle.
REQ-021 A valid synchronized Speed that differs from Speed_cur SHALL be applied as follows:
- outside RUN: immediately;
- in RUN: only in the cycle where the divider is at its terminal count;
- when applied: divider reset to 0 and Speed_chg pulsed in that cycle.
REQ-022 Invalid Speed codes SHALL leave Speed_cur unchanged, and SHALL NOT pulse Speed_chg.
REQ-023 The divider SHALL be 7 bits wide and SHALL never exceed 99.

Reset
REQ-024 On rst_n low, SHALL clear asynchronously: state = DCM_RST with counter 0, Dcm_rst = 1, Clk_ready = 0, Tx_en = 0, Speed_cur = 3'b100, Speed_chg = 0, synchronizers = 0.
REQ-025 Reset asserted mid-operation SHALL abort any pending speed change; the DCM reset sequence restarts after rst_n deasserts.

Configuration
REQ-026 SHALL support macro CLK_SPEED_SCHED_RECOVERY_EN.
REQ-027 With CLK_SPEED_SCHED_RECOVERY_EN defined, a lock drop in RUN SHALL go to DCM_RST (full re-reset).
REQ-028 With CLK_SPEED_SCHED_RECOVERY_EN undefined, a lock drop in RUN SHALL go to WAIT_LOCK without asserting Dcm_rst; the timeout still applies.

Structure
REQ-029 SHALL place the following in package clk_speed_pkg:
- the state enum;
- the speed one-hot constants SPD_1000, SPD_100 and SPD_10;
- the divide constants 1, 10 and 100.
REQ-030 SHALL instantiate the synchronizer as sub-module clk_sync2 (1-bit wide, 2 flops), used four times for Dcm_locked and each Speed bit.

Verification
REQ-031 The bench SHALL cover: release rst_n with Dcm_locked = 1 -> Dcm_rst high for 8 cycles, Clk_ready high 16 cycles after synchronized lock, Tx_en every cycle.
REQ-032 The bench SHALL cover: Dcm_locked held at 0 -> Dcm_rst re-pulses 8 cycles every 4095 + 8 cycles; Clk_ready stays 0.
REQ-033 The bench SHALL cover: in RUN, Speed = 3'b010 -> Speed_chg pulses once, then Tx_en every 10th cycle; next, Speed = 3'b001 -> switch occurs at a divider terminal count, then Tx_en every 100th cycle.
REQ-034 The bench SHALL cover: Speed = 3'b011 in RUN -> Speed_cur unchanged, no Speed_chg.
REQ-035 The bench SHALL cover: lock dropped for 1 cycle in SETTLE -> SETTLE count restarts; lock dropped in RUN -> Tx_en stops, and with the macro Dcm_rst pulses, without it Dcm_rst stays 0.
REQ-036 The bench SHALL cover: rst_n low mid-10M-frame -> all outputs reach reset values with no clock edge.

Source files
------------

// File: rtl/clk_speed_pkg.sv
// Shared state encoding, speed codes and divide ratios for clk_speed_sched.
package clk_speed_pkg;

   typedef enum logic [1:0] {
      DCM_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      SETTLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam logic [2:0] SPD_1000 = 3'b100;
   localparam logic [2:0] SPD_100  = 3'b010;
   localparam logic [2:0] SPD_10   = 3'b001;

   localparam logic [6:0] DIV_1000 = 7'd1;
   localparam logic [6:0] DIV_100  = 7'd10;
   localparam logic [6:0] DIV_10   = 7'd100;

   // Terminal divider value for a one-hot speed; unknown codes fall back to 1000M.
   function automatic logic [6:0] div_last(input logic [2:0] spd);
      case (spd)
         SPD_100: div_last = DIV_100 - 7'd1;
         SPD_10:  div_last = DIV_10 - 7'd1;
         default: div_last = DIV_1000 - 7'd1;
      endcase
   endfunction

   function automatic logic spd_valid(input logic [2:0] spd);
      return (spd == SPD_1000) || (spd == SPD_100) || (spd == SPD_10);
   endfunction

endpackage

// File: rtl/clk_sync2.sv
// Two-flop single-bit synchronizer, cleared by the asynchronous reset.
module clk_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/clk_speed_sched.sv
// DCM reset/lock sequencer with speed-dependent transmit enable divider.
// Optional macro CLK_SPEED_SCHED_RECOVERY_EN: lock loss in RUN forces a full DCM re-reset.
module clk_speed_sched
   import clk_speed_pkg::*;
#(
   parameter int DCM_RST_CYCLES = 8,
   parameter int LOCK_TIMEOUT   = 4095,
   parameter int SETTLE_CYCLES  = 16
) (
   input  logic       Clk_125M,
   input  logic       rst_n,
   input  logic [2:0] Speed,
   input  logic       Dcm_locked,
   output logic       Dcm_rst,
   output logic       Clk_ready,
   output logic       Tx_en,
   output logic [2:0] Speed_cur,
   output logic       Speed_chg
);

   localparam logic [15:0] RST_LAST    = 16'(DCM_RST_CYCLES - 1);
   localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

   state_t      state;
   logic [15:0] cnt;
   logic        lock_s;
   logic [2:0]  spd_s;
   logic [6:0]  div;
   logic        div_tc;
   logic        spd_apply;

   clk_sync2 u_sync_lock (.clk(Clk_125M), .rst_n(rst_n), .d(Dcm_locked), .q(lock_s));

   for (genvar i = 0; i < 3; i++) begin : g_spd_sync
      clk_sync2 u_sync_spd (.clk(Clk_125M), .rst_n(rst_n), .d(Speed[i]), .q(spd_s[i]));
   end

   always_ff @(posedge Clk_125M or negedge rst_n) begin
      if (!rst_n) begin
         state <= DCM_RST;
         cnt   <= '0;
      end else begin
         case (state)
            DCM_RST: begin
               if (cnt == RST_LAST) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            WAIT_LOCK: begin
               // Lock is checked first so it wins over a coincident timeout.
               if (lock_s) begin
                  state <= SETTLE;
                  cnt   <= '0;
               end else if (cnt == LOCK_LAST) begin
                  state <= DCM_RST;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            SETTLE: begin
               if (!lock_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == SETTLE_LAST) begin
                  state <= RUN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RUN: begin
               if (!lock_s) begin
`ifdef CLK_SPEED_SCHED_RECOVERY_EN
                  state <= DCM_RST;
`else
                  state <= WAIT_LOCK;
`endif
                  cnt <= '0;
               end
            end
            default: begin
               state <= DCM_RST;
               cnt   <= '0;
            end
         endcase
      end
   end

   // In RUN a new speed only lands on a frame boundary so no Tx_en period is truncated.
   assign div_tc    = (div == div_last(Speed_cur));
   assign spd_apply = spd_valid(spd_s) && (spd_s != Speed_cur) &&
                      ((state != RUN) || div_tc);

   always_ff @(posedge Clk_125M or negedge rst_n) begin
      if (!rst_n) begin
         Speed_cur <= SPD_1000;
         Speed_chg <= 1'b0;
         div       <= '0;
      end else begin
         Speed_chg <= spd_apply;
         if (spd_apply) begin
            Speed_cur <= spd_s;
         end
         if ((state != RUN) || spd_apply || div_tc) begin
            div <= '0;
         end else begin
            div <= div + 7'd1;
         end
      end
   end

   assign Dcm_rst   = (state == DCM_RST);
   assign Clk_ready = (state == RUN);
   assign Tx_en     = (state == RUN) && (div == 7'd0);

endmodule
